// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter slice.
package data_mem_arb_pkg;

  typedef enum logic {
    SRC_SCALAR = 1'b0,
    SRC_VECTOR = 1'b1
  } mem_src_e;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;
  localparam int unsigned DEFAULT_STARVE_LIMIT    = 8;

endpackage

// File: rtl/data_mem_src_fifo.sv
// In-order FIFO of issuer IDs for transactions whose address phase was granted.
module data_mem_src_fifo
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  mem_src_e      push_src_i,
  input  logic          pop_i,
  output mem_src_e      head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_src_e      mem_q [DEPTH];
  mem_src_e      mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_src_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= SRC_SCALAR;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_mem_outstanding_arbiter.sv
// Shares one OBI data port between scalar core and vector unit; vector has priority,
// scalar gets a bounded starvation override, responses are routed via a source-ID FIFO.
module data_mem_outstanding_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = DEFAULT_STARVE_LIMIT,
  localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sdata_req_i,
  input  logic             sdata_we_i,
  input  logic [3:0]       sdata_be_i,
  input  logic [31:0]      sdata_addr_i,
  input  logic [31:0]      sdata_wdata_i,
  output logic             sdata_gnt_o,
  output logic             sdata_rvalid_o,
  output logic             sdata_err_o,
  output logic [31:0]      sdata_rdata_o,
  input  logic             vdata_req_i,
  input  logic             vdata_we_i,
  input  logic [3:0]       vdata_be_i,
  input  logic [31:0]      vdata_addr_i,
  input  logic [31:0]      vdata_wdata_i,
  input  logic             vect_pending_store_i,
  input  logic             vect_pending_load_i,
  output logic             vdata_gnt_o,
  output logic             vdata_rvalid_o,
  output logic             vdata_err_o,
  output logic [31:0]      vdata_rdata_o,
  output logic             data_req_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic             data_err_i,
  input  logic [31:0]      data_rdata_i,
  output logic [OUT_W-1:0] outstanding_o,
  output logic             protocol_err_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          lock_q, lock_d;
  mem_src_e      lock_src_q, lock_src_d;
  logic          perr_q, perr_d;

  logic          hazard, hold, starved;
  logic          sel_valid;
  mem_src_e      sel_src;
  logic          fifo_full, fifo_empty, push, pop;
  mem_src_e      fifo_head;

  always_comb begin
    hazard    = vect_pending_store_i | (vect_pending_load_i & sdata_we_i);
    hold      = vdata_req_i | hazard;
    starved   = (starve_q == SW'(STARVE_LIMIT)) & ~hazard;
    sel_valid = 1'b0;
    sel_src   = SRC_SCALAR;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_src   = lock_src_q;
    end else if (sdata_req_i & (~hold | starved)) begin
      sel_valid = 1'b1;
    end else if (vdata_req_i) begin
      sel_valid = 1'b1;
      sel_src   = SRC_VECTOR;
    end
  end

  // Address phase mux; idles on scalar fields so an inactive bus is still well defined.
  always_comb begin
    data_we_o    = sdata_we_i;
    data_be_o    = sdata_be_i;
    data_addr_o  = sdata_addr_i;
    data_wdata_o = sdata_wdata_i;
    if (sel_valid && (sel_src == SRC_VECTOR)) begin
      data_we_o    = vdata_we_i;
      data_be_o    = vdata_be_i;
      data_addr_o  = vdata_addr_i;
      data_wdata_o = vdata_wdata_i;
    end
  end

  assign data_req_o  = sel_valid & ~fifo_full;
  assign sdata_gnt_o = data_gnt_i & data_req_o & (sel_src == SRC_SCALAR);
  assign vdata_gnt_o = data_gnt_i & data_req_o & (sel_src == SRC_VECTOR);

  assign push = data_req_o & data_gnt_i;
  assign pop  = data_rvalid_i & ~fifo_empty;

  assign sdata_rvalid_o = pop & (fifo_head == SRC_SCALAR);
  assign vdata_rvalid_o = pop & (fifo_head == SRC_VECTOR);
  assign sdata_err_o    = sdata_rvalid_o & data_err_i;
  assign vdata_err_o    = vdata_rvalid_o & data_err_i;
  assign sdata_rdata_o  = data_rdata_i;
  assign vdata_rdata_o  = data_rdata_i;
  assign protocol_err_o = perr_q;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (data_req_o) begin
      lock_d     = ~data_gnt_i;
      lock_src_d = sel_src;
    end

    // Only blocking by a live vector request counts towards starvation.
    starve_d = starve_q;
    if (!sdata_req_i || sdata_gnt_o) begin
      starve_d = '0;
    end else if (!lock_q && vdata_req_i && !hazard && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    perr_d = perr_q | (data_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q   <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_SCALAR;
      perr_q     <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      perr_q     <= perr_d;
    end
  end

  data_mem_src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_src_i (sel_src),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (outstanding_o)
  );

endmodule
